lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the single-cycle datapath.
- Consumes ALUResult (address), WriteData (store data) and the memory control bits; returns ReadData to the datapath result mux.
- Drives a word-wide valid/ready data bus with byte strobes.
- Asserts Stall to freeze PC/register writeback while a bus transaction is outstanding.
- Handles RV32I byte/halfword/word sizing, sign extension, misalignment and bus timeout.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_ready before abort; counter width = clog2(TIMEOUT+1).
- AW, 32: address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  current instruction is a load.
- MemWrite  input  1  current instruction is a store.
- Funct3  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- ALUResult  input  AW  byte address.
- WriteData  input  32  store data, right-aligned.
- ReadData  output  32  load result, extended, to result mux.
- Stall  output  1  1 = hold PC and suppress RegWrite this cycle.
- MisalignExc  output  1  one-cycle pulse: misaligned access.
- BusFault  output  1  one-cycle pulse: bus_err or timeout.
- bus_req  output  1  transaction valid.
- bus_we  output  1  1 = write.
- bus_addr  output  AW  word-aligned address (low 2 bits = 0).
- bus_wdata  output  32  lane-shifted store data.
- bus_wstrb  output  4  byte enables.
- bus_ready  input  1  transaction accepted/completed this cycle.
- bus_rdata  input  32  read word, valid with bus_ready.
- bus_err  input  1  error response, valid with bus_ready.

Behaviour:
- Reset (reset=0, async): state IDLE, timeout counter 0.
  - Outputs forced to 0: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, ReadData, MisalignExc, BusFault.
  - Stall=0.
- States: IDLE, BUSY, DONE.

IDLE:
- access = MemRead|MemWrite. If both are set, treat as load.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Action: pulse MisalignExc (registered, next cycle); no bus request; stay in IDLE.
  - Stall=0; ReadData=0 for that instruction.
- Aligned access:
  - Stall=1 combinationally.
  - At the clock edge: latch bus_addr={addr[AW-1:2],2'b00}, bus_we, bus_wstrb, bus_wdata, size/sign, addr[1:0]; set bus_req=1; go to BUSY.
- Strobes:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
  - Loads also drive byte/half/word lanes as above (informational).
- wdata:
  - Byte: {4{WriteData[7:0]}}.
  - Half: {2{WriteData[15:0]}}.
  - Word: WriteData.

BUSY:
- Stall=1. bus_req and all bus outputs held stable until bus_ready.
- bus_ready=1 and bus_err=0:
  - Load: ReadData <= selected lane. LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
  - Store: ReadData unchanged.
  - Clear bus_req; go to DONE.
- bus_ready=1 and bus_err=1: pulse BusFault, ReadData<=0, clear bus_req, go to DONE.
- Timeout: counter increments each BUSY cycle without bus_ready. When the counter reaches TIMEOUT:
  - Abort: bus_req<=0, pulse BusFault, ReadData<=0, go to DONE.
  - bus_ready arriving in that same cycle takes priority over the timeout.
- Counter clears on BUSY entry.

DONE:
- Stall=0 for exactly one cycle; datapath writes back ReadData and advances PC.
- Next state IDLE.
- Back-to-back access: the new instruction is evaluated in IDLE the following cycle. No request is issued from DONE.

Latency:
- Minimum 3 cycles per access: IDLE (request latched), BUSY with bus_ready in its first cycle, DONE.
- Non-memory instructions: Stall=0, no added latency.

Other rules:
- ReadData holds its last value outside DONE, except for the misaligned/fault zeroing above.
- Reset mid-BUSY: bus_req drops asynchronously; a late bus_ready afterwards is ignored in IDLE.

Test Plan:
- LW addr 0x0000_0100, bus_ready after 2 wait cycles, rdata 0xDEADBEEF:
  - bus_addr 0x100, wstrb 1111, Stall high 4 cycles, ReadData 0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80FF_0000 → ReadData 0xFFFFFF80.
- LBU same → 0x00000080.
- LHU addr 0x102, rdata 0x1234_5678 → 0x00001234.
- SH addr 0x202, WriteData 0xAAAA_BEEF → bus_we=1, bus_addr 0x200, wstrb 1100, wdata 0xBEEFBEEF, ReadData unchanged.
- LW addr 0x101:
  - MisalignExc pulses 1 cycle; bus_req never rises; Stall stays 0.
  - SH addr 0x001 behaves the same.
- TIMEOUT=4, bus_ready never asserted → BusFault pulse after 4 BUSY cycles, bus_req drops, ReadData 0, DONE then IDLE.
- bus_err with bus_ready on LW → BusFault pulse, ReadData 0.
- Assert reset low mid-BUSY → bus_req, Stall, ReadData 0 immediately (before next clk edge); after release, a stray bus_ready causes no state change.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store unit for the memory stage of a single-cycle RV32I datapath.
// Sizes byte/half/word accesses onto a word-wide valid/ready bus, extends load
// data, and holds the datapath with Stall while a transaction is outstanding.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [2:0]    Funct3,
  input  logic [AW-1:0] ALUResult,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          MisalignExc,
  output logic          BusFault,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_wstrb,
  input  logic          bus_ready,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    off_q;

  logic          access;
  logic          misaligned;
  logic [3:0]    strb;
  logic [31:0]   wdata;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_val;

  // Decode size, alignment, byte strobes and replicated store data from the
  // current instruction.
  always_comb begin
    access     = MemRead | MemWrite;
    misaligned = 1'b0;
    strb       = 4'hF;
    wdata      = WriteData;
    unique case (Funct3[1:0])
      2'b00: begin
        strb  = 4'b0001 << ALUResult[1:0];
        wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        misaligned = ALUResult[0];
        strb       = 4'b0011 << ALUResult[1:0];
        wdata      = {2{WriteData[15:0]}};
      end
      default: begin
        misaligned = (ALUResult[1:0] != 2'b00);
      end
    endcase
  end

  // Select and extend the addressed lane of the returned read word.
  always_comb begin
    lane_b = bus_rdata[7:0];
    unique case (off_q)
      2'd0: lane_b = bus_rdata[7:0];
      2'd1: lane_b = bus_rdata[15:8];
      2'd2: lane_b = bus_rdata[23:16];
      2'd3: lane_b = bus_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (size_q)
      2'b00:   load_val = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_val = bus_rdata;
    endcase
  end

  // Stall while an aligned access is being issued or is in flight; reset wins.
  assign Stall = reset & ((state_q == StBusy) |
                          ((state_q == StIdle) & access & ~misaligned));

  // Access FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      ReadData    <= '0;
      MisalignExc <= 1'b0;
      BusFault    <= 1'b0;
    end else begin
      MisalignExc <= 1'b0;
      BusFault    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (access) begin
            if (misaligned) begin
              MisalignExc <= 1'b1;
              ReadData    <= '0;
            end else begin
              bus_req   <= 1'b1;
              // Both MemRead and MemWrite set is treated as a load.
              bus_we    <= MemWrite & ~MemRead;
              bus_addr  <= {ALUResult[AW-1:2], 2'b00};
              bus_wdata <= wdata;
              bus_wstrb <= strb;
              size_q    <= Funct3[1:0];
              uns_q     <= Funct3[2];
              off_q     <= ALUResult[1:0];
              cnt_q     <= '0;
              state_q   <= StBusy;
            end
          end
        end
        StBusy: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            state_q <= StDone;
            if (bus_err) begin
              BusFault <= 1'b1;
              ReadData <= '0;
            end else if (!bus_we) begin
              ReadData <= load_val;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Counter would reach TIMEOUT on this edge: abort the access.
            bus_req  <= 1'b0;
            BusFault <= 1'b1;
            ReadData <= '0;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage (built with TIMEOUT = 4).
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, MisalignExc, BusFault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic        cap_req, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_strb;
  int          stalls;
  int          busy_cnt;

  lsu_mem_stage #(.TIMEOUT(4), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .MisalignExc(MisalignExc),
    .BusFault   (BusFault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Runs one aligned access from an IDLE negedge; returns at the DONE negedge
  // with inputs released. Bus outputs are captured in the first BUSY cycle.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int waits,
                        input logic [31:0] rdata, input logic err, output int n_stall);
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
    n_stall = 0;
    #1;
    if (Stall) n_stall++;
    @(negedge clk);
    cap_req = bus_req; cap_we = bus_we; cap_addr = bus_addr;
    cap_wdata = bus_wdata; cap_strb = bus_wstrb;
    for (int i = 0; i < waits; i++) begin
      if (Stall) n_stall++;
      @(negedge clk);
    end
    if (Stall) n_stall++;
    bus_ready = 1'b1; bus_rdata = rdata; bus_err = err;
    @(negedge clk);
    bus_ready = 1'b0; bus_err = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    ALUResult = '0; WriteData = '0; bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;

    // Reset state
    #2;
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_strb", {28'd0, bus_wstrb}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Non-memory instruction: no stall
    #1;
    check("nomem_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);

    // LW 0x100, two wait cycles
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, stalls);
    check("lw_req", {31'd0, cap_req}, 32'd1);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_strb", {28'd0, cap_strb}, 32'hF);
    check("lw_we", {31'd0, cap_we}, 32'd0);
    check("lw_stalls", stalls, 32'd4);
    check("lw_done_stall", {31'd0, Stall}, 32'd0);
    check("lw_done_req", {31'd0, bus_req}, 32'd0);
    check("lw_rdata", ReadData, 32'hDEADBEEF);
    @(negedge clk);

    // LB 0x103
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0, stalls);
    check("lb_strb", {28'd0, cap_strb}, 32'h8);
    check("lb_stalls", stalls, 32'd2);
    check("lb_rdata", ReadData, 32'hFFFF_FF80);
    @(negedge clk);

    // LBU 0x103
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0, stalls);
    check("lbu_rdata", ReadData, 32'h0000_0080);
    @(negedge clk);

    // LHU 0x102
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h1234_5678, 1'b0, stalls);
    check("lhu_strb", {28'd0, cap_strb}, 32'hC);
    check("lhu_rdata", ReadData, 32'h0000_1234);
    @(negedge clk);

    // LH 0x102 with negative halfword
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h8001_0000, 1'b0, stalls);
    check("lh_rdata", ReadData, 32'hFFFF_8001);
    @(negedge clk);

    // SH 0x202
    access(1'b0, 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 0, 32'h5555_5555, 1'b0, stalls);
    check("sh_we", {31'd0, cap_we}, 32'd1);
    check("sh_addr", cap_addr, 32'h200);
    check("sh_strb", {28'd0, cap_strb}, 32'hC);
    check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    check("sh_rdata_kept", ReadData, 32'hFFFF_8001);
    @(negedge clk);

    // SB 0x001
    access(1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_0055, 0, 32'h0, 1'b0, stalls);
    check("sb_strb", {28'd0, cap_strb}, 32'h2);
    check("sb_wdata", cap_wdata, 32'h5555_5555);
    @(negedge clk);

    // MemRead and MemWrite both set behaves as a load
    access(1'b1, 1'b1, 3'b010, 32'h104, 32'h0, 0, 32'h1357_9BDF, 1'b0, stalls);
    check("both_we", {31'd0, cap_we}, 32'd0);
    check("both_rdata", ReadData, 32'h1357_9BDF);
    @(negedge clk);

    // Misaligned LW 0x101
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h101;
    #1;
    check("mis_lw_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    MemRead = 1'b0;
    check("mis_lw_exc", {31'd0, MisalignExc}, 32'd1);
    check("mis_lw_req", {31'd0, bus_req}, 32'd0);
    check("mis_lw_rdata", ReadData, 32'd0);
    @(negedge clk);
    check("mis_lw_pulse", {31'd0, MisalignExc}, 32'd0);
    check("mis_lw_req2", {31'd0, bus_req}, 32'd0);

    // Misaligned SH 0x001
    MemWrite = 1'b1; Funct3 = 3'b001; ALUResult = 32'h001; WriteData = 32'h1234;
    #1;
    check("mis_sh_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    MemWrite = 1'b0;
    check("mis_sh_exc", {31'd0, MisalignExc}, 32'd1);
    check("mis_sh_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    check("mis_sh_pulse", {31'd0, MisalignExc}, 32'd0);

    // Load a nonzero value, then time out (never ready)
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h1111_1111, 1'b0, stalls);
    check("pre_to_rdata", ReadData, 32'h1111_1111);
    @(negedge clk);
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h300;
    busy_cnt = 0;
    @(negedge clk);
    while (bus_req && busy_cnt < 20) begin
      busy_cnt++;
      @(negedge clk);
    end
    MemRead = 1'b0;
    check("to_busy_cycles", busy_cnt, 32'd4);
    check("to_fault", {31'd0, BusFault}, 32'd1);
    check("to_req", {31'd0, bus_req}, 32'd0);
    check("to_rdata", ReadData, 32'd0);
    check("to_done_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    check("to_fault_pulse", {31'd0, BusFault}, 32'd0);

    // Ready arriving on the timeout cycle wins
    access(1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 3, 32'hCAFE_F00D, 1'b0, stalls);
    check("edge_stalls", stalls, 32'd5);
    check("edge_fault", {31'd0, BusFault}, 32'd0);
    check("edge_rdata", ReadData, 32'hCAFE_F00D);
    @(negedge clk);

    // Bus error response
    access(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 0, 32'h7777_7777, 1'b1, stalls);
    check("err_fault", {31'd0, BusFault}, 32'd1);
    check("err_rdata", ReadData, 32'd0);
    @(negedge clk);
    check("err_fault_pulse", {31'd0, BusFault}, 32'd0);

    // Reset during BUSY
    access(1'b1, 1'b0, 3'b010, 32'h110, 32'h0, 0, 32'h2468_ACE0, 1'b0, stalls);
    @(negedge clk);
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h400;
    @(negedge clk);
    check("mid_req", {31'd0, bus_req}, 32'd1);
    check("mid_rdata_pre", ReadData, 32'h2468_ACE0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus_req}, 32'd0);
    check("mid_rst_stall", {31'd0, Stall}, 32'd0);
    check("mid_rst_rdata", ReadData, 32'd0);
    @(negedge clk);
    MemRead = 1'b0;
    reset = 1'b1;
    bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ready = 1'b0;
    check("stray_req", {31'd0, bus_req}, 32'd0);
    check("stray_stall", {31'd0, Stall}, 32'd0);
    check("stray_rdata", ReadData, 32'd0);
    check("stray_fault", {31'd0, BusFault}, 32'd0);
    @(negedge clk);

    // Unit still works after the reset
    access(1'b1, 1'b0, 3'b100, 32'h401, 32'h0, 0, 32'h0000_A500, 1'b0, stalls);
    check("post_lbu_rdata", ReadData, 32'h0000_00A5);
    check("post_lbu_stalls", stalls, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
